// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 constants: transmitter state encoding, default bus timings
// and the odd-parity helper used by both the host transmitter and receiver.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SHIFT,
        ACK,
        RELEASE
    } ps2_tx_state_t;

    // 100 us clock inhibit and 15 ms inter-edge timeout at 25 MHz
    localparam int PS2_INHIBIT_CYCLES = 2500;
    localparam int PS2_TIMEOUT_CYCLES = 375000;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 clock and data pins plus a falling-edge
// detector on the synchronized clock.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_in,
    input  logic din_in,
    output logic clk_s,
    output logic din_s,
    output logic clk_fall
);

    logic [1:0] meta_reg;
    logic [1:0] sync_reg;
    logic       clk_prev_reg;

    // Idle bus level is high, so everything resets to 1 to avoid a false edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_reg     <= 2'b11;
            sync_reg     <= 2'b11;
            clk_prev_reg <= 1'b1;
        end else begin
            meta_reg     <= {din_in, clk_in};
            sync_reg     <= meta_reg;
            clk_prev_reg <= sync_reg[0];
        end
    end

    assign clk_s    = sync_reg[0];
    assign din_s    = sync_reg[1];
    assign clk_fall = clk_prev_reg & ~sync_reg[0];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a start bit and
// shifts a command byte out on device-generated clock edges, then checks ACK.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
    input  logic       clk25,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_din_in,
    output logic       ps2_clk_oe,
    output logic       ps2_din_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES);

    ps2_tx_state_t    state_reg, state_next;
    logic [INH_W-1:0] inh_cnt_reg, inh_cnt_next;
    logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
    logic [3:0]       bit_cnt_reg, bit_cnt_next;
    logic [7:0]       data_reg, data_next;
    logic             parity_reg, parity_next;
    logic             din_oe_reg, din_oe_next;
    logic             done_pulse, error_pulse;
    logic             active;
    logic             clk_s, din_s, clk_fall;

    ps2_sync_edge u_sync (
        .clk      (clk25),
        .rst_n    (rst_n),
        .clk_in   (ps2_clk_in),
        .din_in   (ps2_din_in),
        .clk_s    (clk_s),
        .din_s    (din_s),
        .clk_fall (clk_fall)
    );

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            inh_cnt_reg <= '0;
            to_cnt_reg  <= '0;
            bit_cnt_reg <= '0;
            data_reg    <= '0;
            parity_reg  <= 1'b0;
            din_oe_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            inh_cnt_reg <= inh_cnt_next;
            to_cnt_reg  <= to_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            data_reg    <= data_next;
            parity_reg  <= parity_next;
            din_oe_reg  <= din_oe_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        inh_cnt_next = inh_cnt_reg;
        to_cnt_next  = to_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        data_next    = data_reg;
        parity_next  = parity_reg;
        din_oe_next  = din_oe_reg;
        done_pulse   = 1'b0;
        error_pulse  = 1'b0;
        active       = (state_reg == START) || (state_reg == SHIFT) ||
                       (state_reg == ACK)   || (state_reg == RELEASE);

        // Watchdog: reloaded by every device clock edge while the device owns the clock
        if (active) begin
            if (clk_fall) begin
                to_cnt_next = TO_LOAD;
            end else if (to_cnt_reg != '0) begin
                to_cnt_next = to_cnt_reg - TO_W'(1);
            end
        end

        case (state_reg)
            IDLE: begin
                if (tx_valid) begin
                    state_next   = INHIBIT;
                    data_next    = tx_data;
                    parity_next  = odd_parity(tx_data);
                    inh_cnt_next = '0;
                end
            end
            INHIBIT: begin
                if (inh_cnt_reg == INH_LAST) begin
                    state_next   = START;
                    inh_cnt_next = '0;
                    din_oe_next  = 1'b1;
                    to_cnt_next  = TO_LOAD;
                end else begin
                    inh_cnt_next = inh_cnt_reg + INH_W'(1);
                end
            end
            START: begin
                state_next   = SHIFT;
                bit_cnt_next = '0;
            end
            SHIFT: begin
                // Host changes data while the device holds clock low
                if (clk_fall) begin
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg < 4'd8) begin
                        din_oe_next = ~data_reg[bit_cnt_reg[2:0]];
                    end else if (bit_cnt_reg == 4'd8) begin
                        din_oe_next = ~parity_reg;
                    end else begin
                        din_oe_next = 1'b0;
                        state_next  = ACK;
                    end
                end
            end
            ACK: begin
                if (clk_fall) begin
                    if (din_s) begin
                        error_pulse = 1'b1;
                        state_next  = IDLE;
                    end else begin
                        state_next  = RELEASE;
                    end
                end
            end
            RELEASE: begin
                if (clk_s && din_s) begin
                    done_pulse = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (active && (to_cnt_reg == '0) && !clk_fall && !done_pulse) begin
            error_pulse = 1'b1;
            state_next  = IDLE;
        end

        if (state_next == IDLE) begin
            din_oe_next  = 1'b0;
            to_cnt_next  = '0;
            bit_cnt_next = '0;
            inh_cnt_next = '0;
        end
    end

    assign tx_ready   = (state_reg == IDLE) && rst_n;
    assign tx_busy    = (state_reg != IDLE);
    assign ps2_clk_oe = (state_reg == INHIBIT) || (state_reg == START);
    assign ps2_din_oe = din_oe_reg;
    assign tx_done    = done_pulse;
    assign tx_error   = error_pulse;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx with a behavioural PS/2 keyboard model
// on open-drain pins and a frame reference built from the byte value.
module tb_ps2_host_tx;

    localparam int INH = 2500;
    localparam int TMO = 3000;

    localparam int MODE_ACK    = 0;
    localparam int MODE_NACK   = 1;
    localparam int MODE_SILENT = 2;
    localparam int MODE_ABORT  = 3;

    logic       clk25 = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_din_oe, tx_busy, tx_done, tx_error;
    logic       ps2_clk_in, ps2_din_in;
    logic       dev_clk_low = 1'b0;
    logic       dev_din_low = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int acc_cnt = 0;
    int last_done_cyc = -1;
    int last_acc_cyc = -1;

    // Open-drain bus with pull-ups: either side can pull a line low
    assign ps2_clk_in = ~ps2_clk_oe & ~dev_clk_low;
    assign ps2_din_in = ~ps2_din_oe & ~dev_din_low;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk25      (clk25),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_din_in (ps2_din_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_din_oe (ps2_din_oe),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error)
    );

    always #5 clk25 = ~clk25;

    always @(posedge clk25) begin
        cyc <= cyc + 1;
        if (tx_valid && tx_ready) begin
            acc_cnt      <= acc_cnt + 1;
            last_acc_cyc <= cyc;
        end
    end

    always @(negedge clk25) begin
        if (tx_done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (tx_error) err_cnt++;
        if (tx_done && tx_error) both_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bits the device should sample: start 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        logic [10:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Entered on the first negedge after the byte was accepted
    task automatic run_device(input int mode, input int hp, output logic [10:0] frame);
        int n;
        int start_cyc;
        int d0;
        int e0;
        frame = '0;
        d0 = done_cnt;
        e0 = err_cnt;
        n = 0;
        while (ps2_clk_oe && !ps2_din_oe && n < INH + 100) begin
            n++;
            @(negedge clk25);
        end
        check_eq("inhibit_len", n, INH);
        check_eq("start_cycle", {ps2_clk_oe, ps2_din_oe}, 2'b11);
        start_cyc = cyc;
        @(negedge clk25);
        check_eq("clk_released", {ps2_clk_oe, ps2_din_oe}, 2'b01);

        if (mode == MODE_SILENT) begin
            n = 0;
            while (!tx_error && n < TMO + 200) begin
                n++;
                @(negedge clk25);
            end
            check_eq("timeout_latency", cyc - start_cyc, TMO);
            @(negedge clk25);
            check_eq("timeout_lines", {ps2_clk_oe, ps2_din_oe}, 2'b00);
            check_eq("timeout_ready", tx_ready, 1'b1);
            check_eq("timeout_done_cnt", done_cnt - d0, 0);
            check_eq("timeout_err_cnt", err_cnt - e0, 1);
            return;
        end

        for (int k = 0; k < 11; k++) begin
            repeat (hp) @(negedge clk25);
            if (mode == MODE_ABORT && k == 4) begin
                check_eq("abort_in_shift", {tx_busy, ps2_clk_oe}, 2'b10);
                rst_n = 1'b0;
                @(negedge clk25);
                check_eq("abort_lines", {ps2_clk_oe, ps2_din_oe}, 2'b00);
                check_eq("abort_busy", tx_busy, 1'b0);
                rst_n = 1'b1;
                return;
            end
            frame[k] = ps2_din_in;
            dev_clk_low = 1'b1;
            if (k == 10 && mode == MODE_ACK) dev_din_low = 1'b1;
            repeat (hp) @(negedge clk25);
            dev_clk_low = 1'b0;
        end
        dev_din_low = 1'b0;

        if (mode == MODE_ACK) begin
            n = 0;
            while (!tx_done && n < 200) begin
                n++;
                @(negedge clk25);
            end
            check_eq("done_seen", tx_done, 1'b1);
            repeat (2) @(negedge clk25);
            check_eq("ack_done_cnt", done_cnt - d0, 1);
            check_eq("ack_err_cnt", err_cnt - e0, 0);
        end else begin
            repeat (4) @(negedge clk25);
            check_eq("nack_done_cnt", done_cnt - d0, 0);
            check_eq("nack_err_cnt", err_cnt - e0, 1);
            check_eq("nack_ready", tx_ready, 1'b1);
        end
    endtask

    task automatic send(input logic [7:0] d, input int mode, input int hp);
        logic [10:0] fr;
        int g;
        @(negedge clk25);
        tx_data  = d;
        tx_valid = 1'b1;
        g = 0;
        while (!tx_ready && g < 50) begin
            g++;
            @(negedge clk25);
        end
        check_eq("ready_before_send", tx_ready, 1'b1);
        @(negedge clk25);
        tx_valid = 1'b0;
        run_device(mode, hp, fr);
        if (mode == MODE_ACK || mode == MODE_NACK) begin
            check_eq("frame", fr, exp_frame(d));
            $display("[TB] sent 0x%02h mode %0d sampled %011b", d, mode, fr);
        end else begin
            $display("[TB] sent 0x%02h mode %0d", d, mode);
        end
    endtask

    initial begin
        logic [10:0] fr;
        int a0;

        repeat (3) @(negedge clk25);
        check_eq("reset_lines", {ps2_clk_oe, ps2_din_oe}, 2'b00);
        check_eq("reset_busy", tx_busy, 1'b0);
        check_eq("reset_pulses", {tx_done, tx_error}, 2'b00);
        rst_n = 1'b1;
        @(negedge clk25);
        check_eq("ready_after_reset", tx_ready, 1'b1);

        send(8'hED, MODE_ACK, 40);
        send(8'h01, MODE_ACK, 35);
        send(8'hFF, MODE_ACK, 45);
        for (int i = 0; i < 4; i++) begin
            send(8'($urandom_range(0, 255)), MODE_ACK, int'($urandom_range(25, 60)));
        end
        send(8'($urandom_range(0, 255)), MODE_NACK, 30);
        send(8'h55, MODE_SILENT, 30);
        send(8'h3C, MODE_ABORT, 30);
        send(8'hF4, MODE_ACK, 40);

        // Byte held on tx_valid through a transfer must wait for the first IDLE cycle
        a0 = acc_cnt;
        @(negedge clk25);
        tx_data  = 8'hED;
        tx_valid = 1'b1;
        @(negedge clk25);
        tx_data = 8'hAA;
        run_device(MODE_ACK, 40, fr);
        check_eq("held_frame_ed", fr, exp_frame(8'hED));
        check_eq("held_accept_cycle", last_acc_cyc, last_done_cyc + 1);
        check_eq("held_accept_count", acc_cnt - a0, 2);
        tx_valid = 1'b0;
        run_device(MODE_ACK, 40, fr);
        check_eq("held_frame_aa", fr, exp_frame(8'hAA));
        $display("[TB] held-valid 0xED then 0xAA sampled %011b", fr);

        check_eq("done_error_exclusive", both_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
